usb_hub_ctrl: RTL and testbench
===============================

USB_HUB_CTRL -- requirements
Module: usb_hub_ctrl

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of downstream ports, legal range 1..8.
REQ-002 Parameter RESET_TIMEOUT, default 480000: consecutive SE0 cycles that constitute a bus reset (10 ms at 48 MHz).
REQ-003 Parameter SUSPEND_TIMEOUT, default 144000: consecutive J cycles that constitute suspend (3 ms).
REQ-004 Parameter PORT_RST_CYCLES, default 480000: duration of a downstream port reset.
REQ-005 clk  input  1  sole clock.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 DP, DM  input  1 each  raw upstream bus lines; {DP,DM}: 00=SE0, 10=J, 01=K, 11=SE1.
REQ-008 addr_valid  input  1  one-cycle strobe: SET_ADDRESS data received.
REQ-009 addr_in  input  7  address accompanying addr_valid.
REQ-010 status_done  input  1  one-cycle strobe: control status stage completed.
REQ-011 port_rst_req  input  NUM_PORTS  per-port reset request strobes.
REQ-012 line_state  output  2  synchronized {DP,DM}.
REQ-013 bus_reset  output  1  one-cycle pulse on bus reset detection.
REQ-014 suspended  output  1  level, high while in SUSPEND.
REQ-015 resume  output  1  one-cycle pulse on leaving SUSPEND via K.
REQ-016 dev_addr  output  7  committed device address.
REQ-017 port_rst  output  NUM_PORTS  per-port reset drive, level.
REQ-018 port_en  output  NUM_PORTS  per-port enabled flag.

Function
REQ-019 DP/DM shall pass through a 2-flop synchronizer; line_state and all detection shall use the synchronized value (2-cycle latency).
REQ-020 SE0 counter shall increment each synchronized SE0 cycle, clear on any non-SE0 cycle, and saturate at RESET_TIMEOUT.
REQ-021 bus_reset shall pulse exactly once, on the cycle the SE0 counter reaches RESET_TIMEOUT; continued SE0 shall not re-pulse.
REQ-022 On bus_reset: dev_addr, pending address, port_rst, port_en, all port counters shall clear; state shall go ACTIVE.
REQ-023 State machine: states ACTIVE, SUSPEND; reset state ACTIVE.
REQ-024 ACTIVE->SUSPEND when the consecutive-J counter reaches SUSPEND_TIMEOUT; counter clears on any non-J cycle.
REQ-025 SUSPEND->ACTIVE on the first synchronized K cycle, with resume pulsed that same cycle; SE1 in SUSPEND shall be ignored.
REQ-026 SE0 counting shall continue in SUSPEND; bus_reset exits SUSPEND without resume pulse.
REQ-027 addr_valid shall store addr_in as pending (overwriting any prior pending); dev_addr shall not change.
REQ-028 status_done with pending set shall commit pending to dev_addr next cycle and clear pending; without pending it shall do nothing.
REQ-029 addr_valid and status_done in the same cycle shall commit addr_in directly.
REQ-030 port_rst_req[i] while port_rst[i] low and not SUSPEND shall assert port_rst[i], clear port_en[i], and load a per-port counter.
REQ-031 port_rst[i] shall remain high exactly PORT_RST_CYCLES cycles, then deassert with port_en[i] set the same cycle.
REQ-032 port_rst_req[i] while port_rst[i] high, or while SUSPEND, shall be ignored; ports operate independently and concurrently.
REQ-033 Counter widths shall be $clog2(max timeout+1); no wrap is permitted.

Reset
REQ-034 rst_n low shall asynchronously force: synchronizer to J, line_state=2'b10, bus_reset=0, suspended=0, resume=0, dev_addr=0, pending cleared, port_rst=0, port_en=0, all counters 0, state ACTIVE.
REQ-035 rst_n deassertion mid-port-reset or mid-SE0 shall restart from reset values; no partial state survives.

Verification
REQ-036 SE0 held RESET_TIMEOUT+100 cycles after dev_addr=7'h05 -> single bus_reset pulse RESET_TIMEOUT+2 cycles after first SE0; dev_addr=0.
REQ-037 J held SUSPEND_TIMEOUT cycles -> suspended=1; then one K cycle -> resume pulse, suspended=0; port_rst_req during suspend -> no port_rst.
REQ-038 addr_valid addr_in=7'h12, later status_done -> dev_addr=7'h12 next cycle; status_done alone again -> unchanged.
REQ-039 Simultaneous addr_valid addr_in=7'h33 and status_done -> dev_addr=7'h33; prior pending 7'h12 discarded.
REQ-040 port_rst_req=4'b0101, then repeat on bit 0 mid-reset -> port_rst[0],[2] high exactly PORT_RST_CYCLES, port_en=4'b0101 after; repeat ignored.
REQ-041 rst_n asserted mid-port-reset -> all outputs to REQ-034 values immediately, no clock edge required.

Source files
------------

// File: rtl/usb_hub_ctrl.sv
// rtl/usb_hub_ctrl.sv - USB hub upstream line monitor, address commit and downstream port reset control
module usb_hub_ctrl #(
  parameter int NUM_PORTS       = 4,
  parameter int RESET_TIMEOUT   = 480000,
  parameter int SUSPEND_TIMEOUT = 144000,
  parameter int PORT_RST_CYCLES = 480000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 dp_i,
  input  logic                 dm_i,
  input  logic                 addr_valid_i,
  input  logic [6:0]           addr_in_i,
  input  logic                 status_done_i,
  input  logic [NUM_PORTS-1:0] port_rst_req_i,
  output logic [1:0]           line_state_o,
  output logic                 bus_reset_o,
  output logic                 suspended_o,
  output logic                 resume_o,
  output logic [6:0]           dev_addr_o,
  output logic [NUM_PORTS-1:0] port_rst_o,
  output logic [NUM_PORTS-1:0] port_en_o
);

  localparam int RW = $clog2(RESET_TIMEOUT + 1);
  localparam int SW = $clog2(SUSPEND_TIMEOUT + 1);
  localparam int PW = $clog2(PORT_RST_CYCLES + 1);

  localparam logic [RW-1:0] RST_MAX = RW'(RESET_TIMEOUT);
  localparam logic [SW-1:0] SUS_MAX = SW'(SUSPEND_TIMEOUT);
  localparam logic [PW-1:0] PRT_MAX = PW'(PORT_RST_CYCLES);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_SUSPEND = 1'b1
  } state_e;

  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    ls;
  logic [RW-1:0] se0_cnt_q, se0_cnt_d;
  logic [SW-1:0] j_cnt_q, j_cnt_d;
  state_e        state_q, state_d;
  logic          bus_reset_q, bus_reset_d;
  logic          bus_rst_hit;
  logic          resume;
  logic [6:0]    dev_addr_q, dev_addr_d;
  logic [6:0]    pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [NUM_PORTS-1:0]         port_rst_q, port_rst_d;
  logic [NUM_PORTS-1:0]         port_en_q, port_en_d;
  logic [NUM_PORTS-1:0][PW-1:0] pcnt_q, pcnt_d;

  assign ls = sync2_q;

  // Two-flop synchronizer for the raw bus lines; idles at J out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= LS_J;
      sync2_q <= LS_J;
    end else begin
      sync1_q <= {dp_i, dm_i};
      sync2_q <= sync1_q;
    end
  end

  // Line-state counters and ACTIVE/SUSPEND next-state logic.
  always_comb begin
    se0_cnt_d   = se0_cnt_q;
    j_cnt_d     = j_cnt_q;
    state_d     = state_q;
    resume      = 1'b0;
    bus_rst_hit = (ls == LS_SE0) && (se0_cnt_q == RST_MAX - RW'(1));

    if (ls == LS_SE0) begin
      if (se0_cnt_q != RST_MAX) se0_cnt_d = se0_cnt_q + RW'(1);
    end else begin
      se0_cnt_d = '0;
    end

    if (ls == LS_J) begin
      if (j_cnt_q != SUS_MAX) j_cnt_d = j_cnt_q + SW'(1);
    end else begin
      j_cnt_d = '0;
    end

    case (state_q)
      ST_ACTIVE: begin
        if (ls == LS_J && j_cnt_q == SUS_MAX - SW'(1)) state_d = ST_SUSPEND;
      end
      ST_SUSPEND: begin
        // Bus reset leaves suspend silently; SE1 is simply ignored here.
        if (bus_rst_hit) begin
          state_d = ST_ACTIVE;
        end else if (ls == LS_K) begin
          state_d = ST_ACTIVE;
          resume  = 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase

    bus_reset_d = bus_rst_hit;
  end

  // Pending/committed address handling; bus reset wins over any strobe.
  always_comb begin
    dev_addr_d = dev_addr_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    if (bus_rst_hit) begin
      dev_addr_d = '0;
      pend_d     = '0;
      pend_v_d   = 1'b0;
    end else if (addr_valid_i && status_done_i) begin
      dev_addr_d = addr_in_i;
      pend_d     = '0;
      pend_v_d   = 1'b0;
    end else if (addr_valid_i) begin
      pend_d     = addr_in_i;
      pend_v_d   = 1'b1;
    end else if (status_done_i && pend_v_q) begin
      dev_addr_d = pend_q;
      pend_d     = '0;
      pend_v_d   = 1'b0;
    end
  end

  // Independent per-port reset timers; a port enables as its reset drops.
  always_comb begin
    port_rst_d = port_rst_q;
    port_en_d  = port_en_q;
    pcnt_d     = pcnt_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus_rst_hit) begin
        port_rst_d[i] = 1'b0;
        port_en_d[i]  = 1'b0;
        pcnt_d[i]     = '0;
      end else if (port_rst_q[i]) begin
        if (pcnt_q[i] == PW'(1)) begin
          port_rst_d[i] = 1'b0;
          port_en_d[i]  = 1'b1;
          pcnt_d[i]     = '0;
        end else begin
          pcnt_d[i] = pcnt_q[i] - PW'(1);
        end
      end else if (port_rst_req_i[i] && state_q != ST_SUSPEND) begin
        port_rst_d[i] = 1'b1;
        port_en_d[i]  = 1'b0;
        pcnt_d[i]     = PRT_MAX;
      end
    end
  end

  // State register for everything behind the synchronizer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      se0_cnt_q   <= '0;
      j_cnt_q     <= '0;
      state_q     <= ST_ACTIVE;
      bus_reset_q <= 1'b0;
      dev_addr_q  <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      port_rst_q  <= '0;
      port_en_q   <= '0;
      pcnt_q      <= '0;
    end else begin
      se0_cnt_q   <= se0_cnt_d;
      j_cnt_q     <= j_cnt_d;
      state_q     <= state_d;
      bus_reset_q <= bus_reset_d;
      dev_addr_q  <= dev_addr_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      port_rst_q  <= port_rst_d;
      port_en_q   <= port_en_d;
      pcnt_q      <= pcnt_d;
    end
  end

  assign line_state_o = sync2_q;
  assign bus_reset_o  = bus_reset_q;
  assign suspended_o  = (state_q == ST_SUSPEND);
  assign resume_o     = resume;
  assign dev_addr_o   = dev_addr_q;
  assign port_rst_o   = port_rst_q;
  assign port_en_o    = port_en_q;

endmodule

// File: tb/tb_usb_hub_ctrl.sv
// tb/tb_usb_hub_ctrl.sv - directed self-checking bench for usb_hub_ctrl
module tb_usb_hub_ctrl;

  localparam int NP  = 4;
  localparam int RT  = 20;
  localparam int ST  = 15;
  localparam int PRC = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dp, dm;
  logic          addr_valid;
  logic [6:0]    addr_in;
  logic          status_done;
  logic [NP-1:0] port_rst_req;
  logic [1:0]    line_state;
  logic          bus_reset;
  logic          suspended;
  logic          resume;
  logic [6:0]    dev_addr;
  logic [NP-1:0] port_rst;
  logic [NP-1:0] port_en;

  int pass_cnt = 0;
  int total    = 0;

  usb_hub_ctrl #(
    .NUM_PORTS(NP), .RESET_TIMEOUT(RT), .SUSPEND_TIMEOUT(ST), .PORT_RST_CYCLES(PRC)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .dp_i(dp), .dm_i(dm),
    .addr_valid_i(addr_valid), .addr_in_i(addr_in), .status_done_i(status_done),
    .port_rst_req_i(port_rst_req), .line_state_o(line_state), .bus_reset_o(bus_reset),
    .suspended_o(suspended), .resume_o(resume), .dev_addr_o(dev_addr),
    .port_rst_o(port_rst), .port_en_o(port_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (line_state !== 2'b10) $display("FAIL reset_line_state got %b exp 10", line_state); else pass_cnt++;
    total++; if (bus_reset !== 1'b0) $display("FAIL reset_bus_reset got %b exp 0", bus_reset); else pass_cnt++;
    total++; if (suspended !== 1'b0 || resume !== 1'b0) $display("FAIL reset_susp_resume got %b%b exp 00", suspended, resume); else pass_cnt++;
    total++; if (dev_addr !== 7'h00) $display("FAIL reset_dev_addr got %h exp 00", dev_addr); else pass_cnt++;
    total++; if (port_rst !== 4'b0 || port_en !== 4'b0) $display("FAIL reset_ports got %b/%b exp 0000/0000", port_rst, port_en); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    total++; if (line_state !== 2'b01) $display("FAIL sync_line_state got %b exp 01", line_state); else pass_cnt++;
  endtask

  task automatic test_address();
    addr_in = 7'h12; addr_valid = 1'b1;
    tick();
    addr_valid = 1'b0;
    total++; if (dev_addr !== 7'h00) $display("FAIL addr_pending_only got %h exp 00", dev_addr); else pass_cnt++;
    tick(); tick();
    status_done = 1'b1;
    tick();
    status_done = 1'b0;
    total++; if (dev_addr !== 7'h12) $display("FAIL addr_commit got %h exp 12", dev_addr); else pass_cnt++;
    status_done = 1'b1;
    tick();
    status_done = 1'b0;
    total++; if (dev_addr !== 7'h12) $display("FAIL addr_status_alone got %h exp 12", dev_addr); else pass_cnt++;
  endtask

  task automatic test_addr_simultaneous();
    addr_in = 7'h12; addr_valid = 1'b1;
    tick();
    addr_in = 7'h33; status_done = 1'b1;
    tick();
    addr_valid = 1'b0; status_done = 1'b0;
    total++; if (dev_addr !== 7'h33) $display("FAIL addr_simul got %h exp 33", dev_addr); else pass_cnt++;
    status_done = 1'b1;
    tick();
    status_done = 1'b0;
    total++; if (dev_addr !== 7'h33) $display("FAIL addr_pending_discarded got %h exp 33", dev_addr); else pass_cnt++;
  endtask

  task automatic test_bus_reset();
    int first = 0;
    int pulses = 0;
    addr_in = 7'h05; addr_valid = 1'b1; status_done = 1'b1;
    tick();
    status_done = 1'b0; addr_in = 7'h44;
    tick();
    addr_valid = 1'b0;
    total++; if (dev_addr !== 7'h05) $display("FAIL busrst_preset got %h exp 05", dev_addr); else pass_cnt++;
    dp = 1'b0; dm = 1'b0;
    for (int n = 1; n <= RT + 100; n++) begin
      tick();
      if (bus_reset === 1'b1) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    total++; if (pulses != 1) $display("FAIL busrst_pulse_count got %0d exp 1", pulses); else pass_cnt++;
    total++; if (first != RT + 2) $display("FAIL busrst_latency got %0d exp %0d", first, RT + 2); else pass_cnt++;
    total++; if (dev_addr !== 7'h00) $display("FAIL busrst_dev_addr got %h exp 00", dev_addr); else pass_cnt++;
    total++; if (line_state !== 2'b00) $display("FAIL busrst_line_state got %b exp 00", line_state); else pass_cnt++;
    dp = 1'b0; dm = 1'b1;
    tick(); tick(); tick();
    status_done = 1'b1;
    tick();
    status_done = 1'b0;
    total++; if (dev_addr !== 7'h00) $display("FAIL busrst_pending_cleared got %h exp 00", dev_addr); else pass_cnt++;
  endtask

  task automatic test_suspend_resume();
    int first = 0;
    int rpulses = 0;
    int rfirst = 0;
    dp = 1'b1; dm = 1'b0;
    for (int n = 1; n <= ST + 5; n++) begin
      tick();
      if (suspended === 1'b1 && first == 0) first = n;
    end
    total++; if (first != ST + 2) $display("FAIL suspend_latency got %0d exp %0d", first, ST + 2); else pass_cnt++;
    port_rst_req = 4'b1111;
    tick();
    port_rst_req = 4'b0000;
    tick();
    total++; if (port_rst !== 4'b0000) $display("FAIL suspend_port_req got %b exp 0000", port_rst); else pass_cnt++;
    dp = 1'b1; dm = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (resume === 1'b1) rpulses++;
    end
    total++; if (suspended !== 1'b1 || rpulses != 0) $display("FAIL suspend_se1 got susp=%b resumes=%0d exp 1/0", suspended, rpulses); else pass_cnt++;
    dp = 1'b0; dm = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (resume === 1'b1) begin
        rpulses++;
        if (rfirst == 0) rfirst = n;
      end
    end
    total++; if (rpulses != 1 || rfirst != 2) $display("FAIL resume_pulse got count=%0d at=%0d exp 1 at 2", rpulses, rfirst); else pass_cnt++;
    total++; if (suspended !== 1'b0) $display("FAIL resume_suspended got %b exp 0", suspended); else pass_cnt++;
  endtask

  task automatic test_port_reset();
    int high0 = 0;
    int high2 = 0;
    port_rst_req = 4'b0101;
    tick();
    port_rst_req = 4'b0000;
    total++; if (port_rst !== 4'b0101 || port_en !== 4'b0000) $display("FAIL port_assert got %b/%b exp 0101/0000", port_rst, port_en); else pass_cnt++;
    if (port_rst[0] === 1'b1) high0++;
    if (port_rst[2] === 1'b1) high2++;
    for (int n = 1; n <= PRC + 6; n++) begin
      port_rst_req = (n == 3) ? 4'b0001 : (n == 4) ? 4'b1000 : 4'b0000;
      tick();
      if (port_rst[0] === 1'b1) high0++;
      if (port_rst[2] === 1'b1) high2++;
      if (n == PRC) begin
        total++; if (port_en !== 4'b0101 || port_rst !== 4'b1000) $display("FAIL port_release got %b/%b exp en 0101 rst 1000", port_en, port_rst); else pass_cnt++;
      end
    end
    port_rst_req = 4'b0000;
    total++; if (high0 != PRC) $display("FAIL port0_width got %0d exp %0d", high0, PRC); else pass_cnt++;
    total++; if (high2 != PRC) $display("FAIL port2_width got %0d exp %0d", high2, PRC); else pass_cnt++;
    total++; if (port_en !== 4'b1101 || port_rst !== 4'b0000) $display("FAIL port_final got %b/%b exp en 1101 rst 0000", port_en, port_rst); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    addr_in = 7'h21; addr_valid = 1'b1; status_done = 1'b1;
    tick();
    status_done = 1'b0; addr_in = 7'h55;
    port_rst_req = 4'b0010;
    tick();
    addr_valid = 1'b0; port_rst_req = 4'b0000;
    tick();
    total++; if (port_rst !== 4'b0010 || dev_addr !== 7'h21) $display("FAIL async_pre got rst=%b addr=%h exp 0010/21", port_rst, dev_addr); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (port_rst !== 4'b0000 || port_en !== 4'b0000) $display("FAIL async_ports got %b/%b exp 0000/0000", port_rst, port_en); else pass_cnt++;
    total++; if (dev_addr !== 7'h00) $display("FAIL async_dev_addr got %h exp 00", dev_addr); else pass_cnt++;
    total++; if (line_state !== 2'b10 || suspended !== 1'b0 || resume !== 1'b0 || bus_reset !== 1'b0) $display("FAIL async_misc got ls=%b s=%b r=%b b=%b exp 10/0/0/0", line_state, suspended, resume, bus_reset); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    total++; if (port_rst !== 4'b0000 || port_en !== 4'b0000) $display("FAIL async_no_resume_port got %b/%b exp 0000/0000", port_rst, port_en); else pass_cnt++;
    status_done = 1'b1;
    tick();
    status_done = 1'b0;
    total++; if (dev_addr !== 7'h00) $display("FAIL async_pending_cleared got %h exp 00", dev_addr); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; dp = 1'b0; dm = 1'b1;
    addr_valid = 1'b0; addr_in = 7'h00; status_done = 1'b0; port_rst_req = '0;
    test_reset();
    test_address();
    test_addr_simultaneous();
    test_bus_reset();
    test_suspend_resume();
    test_port_reset();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
